// File: rtl/score_pkg.sv
// Shared constants for the BCD score counter and its digit cells.
package score_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  BCD_ZERO   = 4'd0;
  localparam int unsigned MAX_DIGITS = 8;

endpackage : score_pkg

// File: rtl/bcd_digit.sv
// One decimal digit of the score: a 4-bit register that counts 0..9 and
// passes a carry to the next digit when it rolls over.
module bcd_digit
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // Carry ripples on combinationally so a whole chain settles in one cycle.
  assign cout = cin & (q == BCD_MAX);

  // Digit register: clear beats increment; 9 rolls to 0 so 10..15 never appear.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= BCD_ZERO;
    end else if (clr) begin
      q <= BCD_ZERO;
    end else if (cin) begin
      q <= (q == BCD_MAX) ? BCD_ZERO : q + BCD_W'(1);
    end
  end

endmodule : bcd_digit

// File: rtl/score_bcd_counter.sv
// Multi-digit BCD distance score with saturation and a latched high score.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    inc,
  input  logic                    clear,
  input  logic                    game_over,
  output logic [BCD_W*DIGITS-1:0] score_bcd,
  output logic [BCD_W*DIGITS-1:0] hi_bcd,
  output logic                    saturated,
  output logic                    new_high
);

  localparam int unsigned W         = BCD_W * DIGITS;
  localparam logic [3:0]  BCD_EIGHT = BCD_MAX - BCD_W'(1);

  logic [DIGITS:0] carry;
  logic [W-1:0]    score;
  logic            next_nines;
  logic            sat_next;

  // Increment request entering the ones digit.
  assign carry[0] = run & inc & ~clear & ~saturated;

  // Digit chain, ones digit first.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .cin   (carry[i]),
      .q     (score[BCD_W*i +: BCD_W]),
      .cout  (carry[i+1])
    );
  end

  assign score_bcd = score;

  // Predict whether every digit will read 9 after this edge.
  always_comb begin
    next_nines = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry[i]) begin
        if (score[BCD_W*i +: BCD_W] != BCD_EIGHT) next_nines = 1'b0;
      end else begin
        if (score[BCD_W*i +: BCD_W] != BCD_MAX) next_nines = 1'b0;
      end
    end
    sat_next = ~clear & ~carry[DIGITS] & next_nines;
  end

  // Saturation flag tracks the score register cycle for cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      saturated <= 1'b0;
    end else begin
      saturated <= sat_next;
    end
  end

  // High-score latch compares the pre-update score; BCD packing keeps numeric order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_bcd   <= '0;
      new_high <= 1'b0;
    end else begin
      new_high <= 1'b0;
      if (game_over && (score > hi_bcd)) begin
        hi_bcd   <= score;
        new_high <= 1'b1;
      end
    end
  end

endmodule : score_bcd_counter

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: integer reference model,
// per-cycle compare process, directed scenarios and a random phase.
module tb_score_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          SMAX   = 9999;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0;
  logic         inc = 1'b0;
  logic         clear = 1'b0;
  logic         game_over = 1'b0;
  logic [W-1:0] score_bcd;
  logic [W-1:0] hi_bcd;
  logic         saturated;
  logic         new_high;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  // Reference model state, as plain integers.
  int m_score = 0;
  int m_hi    = 0;
  bit m_new   = 1'b0;

  score_bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .inc       (inc),
    .clear     (clear),
    .game_over (game_over),
    .score_bcd (score_bcd),
    .hi_bcd    (hi_bcd),
    .saturated (saturated),
    .new_high  (new_high)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then advance the model by the same rules.
  task automatic step(input bit r, input bit ru, input bit in, input bit cl, input bit go);
    reset = r; run = ru; inc = in; clear = cl; game_over = go;
    @(posedge clk);
    if (r) begin
      m_score = 0; m_hi = 0; m_new = 1'b0;
    end else begin
      m_new = 1'b0;
      if (go && m_score > m_hi) begin
        m_hi  = m_score;
        m_new = 1'b1;
      end
      if (cl) m_score = 0;
      else if (ru && in && m_score < SMAX) m_score = m_score + 1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0);
  endtask

  // Compare process: every cycle, all outputs against the model plus digit legality.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
      chk("hi", 32'(hi_bcd), 32'(to_bcd(m_hi)));
      chk("saturated", 32'(saturated), 32'(m_score == SMAX));
      chk("new_high", 32'(new_high), 32'(m_new));
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (score_bcd[4*i +: 4] > 4'd9 || hi_bcd[4*i +: 4] > 4'd9) begin
          chk("nibble_range", 32'({score_bcd, hi_bcd}), 32'(0));
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // 1. reset then idle
    step(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_hi", 32'(hi_bcd), 32'h0);
    chk("rst_flags", 32'({saturated, new_high}), 32'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("idle_score", 32'(score_bcd), 32'h0);

    // 2. basic counting and multi-digit carry
    incs(10);
    chk("ten", 32'(score_bcd), 32'h0010);
    incs(89);
    chk("n99", 32'(score_bcd), 32'h0099);
    incs(1);
    chk("n100", 32'(score_bcd), 32'h0100);

    // 3. saturation at all-9s
    step(1, 0, 0, 0, 0);
    incs(9998);
    chk("pre_sat", 32'(score_bcd), 32'h9998);
    chk("pre_sat_flag", 32'(saturated), 32'h0);
    incs(1);
    chk("sat_val", 32'(score_bcd), 32'h9999);
    chk("sat_flag", 32'(saturated), 32'h1);
    incs(2);
    chk("sat_hold", 32'(score_bcd), 32'h9999);
    chk("sat_flag_hold", 32'(saturated), 32'h1);

    // 4. high score latch, then a lower game
    step(1, 0, 0, 0, 0);
    incs(42);
    step(0, 1, 0, 0, 1);
    chk("hi42", 32'(hi_bcd), 32'h0042);
    chk("nh_pulse", 32'(new_high), 32'h1);
    idle(1);
    chk("nh_drop", 32'(new_high), 32'h0);
    step(0, 1, 0, 1, 0);
    incs(17);
    step(0, 1, 0, 0, 1);
    chk("hi_keep", 32'(hi_bcd), 32'h0042);
    chk("nh_none", 32'(new_high), 32'h0);

    // 5. game_over+clear, then clear+inc
    incs(106);
    chk("s123", 32'(score_bcd), 32'h0123);
    step(0, 1, 0, 1, 1);
    chk("hi123", 32'(hi_bcd), 32'h0123);
    chk("go_clr_score", 32'(score_bcd), 32'h0);
    incs(5);
    step(0, 1, 1, 1, 0);
    chk("clr_inc", 32'(score_bcd), 32'h0);

    // game_over+inc uses the old score
    incs(200);
    step(0, 1, 1, 0, 1);
    chk("go_inc_hi", 32'(hi_bcd), 32'h0200);
    chk("go_inc_score", 32'(score_bcd), 32'h0201);

    // 6. run low blocks inc; reset mid-run
    step(0, 1, 0, 1, 0);
    incs(555);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    chk("run_low", 32'(score_bcd), 32'h0555);
    step(1, 1, 1, 0, 1);
    chk("mid_rst", 32'({score_bcd, hi_bcd, saturated, new_high}), 32'h0);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
           $urandom_range(0, 19) == 0);
    end
    // Random traffic near the top of the range
    step(0, 1, 0, 1, 0);
    incs(9990);
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 9) == 0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_score_bcd_counter
